// File: rtl/intc_benes_pipe.sv
// Pipelined Benes permutation network (one register per stage) with shadow/active switch
// configuration; commits drain the pipe first. Define INTC_BENES_BEAT_CNT_EN to add o_beat_cnt.
module intc_benes_pipe #(
  parameter  int DATA_WIDTH = 512,
  parameter  int PORTS      = 32,
  localparam int L          = $clog2(PORTS),
  localparam int STAGES     = 2*L-1,
  localparam int SWITCHES   = PORTS/2,
  localparam int STG_W      = $clog2(STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_data [0:PORTS-1],
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data [0:PORTS-1],
  input  logic                  cfg_wr,
  input  logic [STG_W-1:0]      cfg_stage,
  input  logic [SWITCHES-1:0]   cfg_bits,
  input  logic                  cfg_commit,
  output logic                  cfg_busy
`ifdef INTC_BENES_BEAT_CNT_EN
  ,
  output logic [31:0]           o_beat_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] stage_q [0:STAGES-1][0:PORTS-1];
  logic [DATA_WIDTH-1:0] stage_d [0:STAGES-1][0:PORTS-1];
  logic [STAGES-1:0]     vld_q;
  logic [SWITCHES-1:0]   shadow_q [0:STAGES-1];
  logic [SWITCHES-1:0]   active_q [0:STAGES-1];
  logic                  adv;
  logic                  accept;
  logic                  cfg_wr_ok;

  // Source position (in the switch-output vector) feeding output position p of stage s.
  function automatic int perm_src(int s, int p);
    int blk, base, j, r;
    r = p;
    if (s < L-1) begin
      blk  = PORTS >> s;
      base = (p / blk) * blk;
      j    = p % blk;
      r    = (j < blk/2) ? base + 2*j : base + 2*(j - blk/2) + 1;
    end else if (s < STAGES-1) begin
      blk  = 4 << (s - (L-1));
      base = (p / blk) * blk;
      j    = p % blk;
      r    = (j % 2 == 0) ? base + j/2 : base + blk/2 + j/2;
    end
    return r;
  endfunction

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar p = 0; p < PORTS; p++) begin : g_port
      localparam int SRC = perm_src(s, p);
      localparam int SW  = SRC / 2;
      logic [DATA_WIDTH-1:0] straight;
      logic [DATA_WIDTH-1:0] crossed;
      if (s == 0) begin : g_first
        assign straight = i_data[SRC];
        assign crossed  = i_data[SRC ^ 1];
      end else begin : g_next
        assign straight = stage_q[s-1][SRC];
        assign crossed  = stage_q[s-1][SRC ^ 1];
      end
      assign stage_d[s][p] = active_q[s][SW] ? crossed : straight;
    end
  end

  assign o_valid   = vld_q[STAGES-1];
  assign adv       = !o_valid || o_ready;
  // rst_n gates i_ready so no beat looks accepted while reset is held.
  assign i_ready   = rst_n && adv && (state_q == RUN);
  assign accept    = i_valid && i_ready;
  assign cfg_busy  = (state_q != RUN);
  assign cfg_wr_ok = cfg_wr && (int'(cfg_stage) < STAGES);

  always_comb begin
    for (int p = 0; p < PORTS; p++) o_data[p] = stage_q[STAGES-1][p];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++)
        for (int p = 0; p < PORTS; p++) stage_q[s][p] <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-2:0], accept};
      for (int s = 0; s < STAGES; s++)
        for (int p = 0; p < PORTS; p++) stage_q[s][p] <= stage_d[s][p];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_commit) state_d = DRAIN;
      DRAIN:   if (vld_q == '0) state_d = APPLY;
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // A write in the commit cycle lands in shadow before APPLY copies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        shadow_q[s] <= '0;
        active_q[s] <= '0;
      end
    end else begin
      if (cfg_wr_ok) shadow_q[cfg_stage] <= cfg_bits;
      if (state_q == APPLY)
        for (int s = 0; s < STAGES; s++) active_q[s] <= shadow_q[s];
    end
  end

`ifdef INTC_BENES_BEAT_CNT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  beat_cnt_q <= '0;
    else if (o_valid && o_ready) beat_cnt_q <= beat_cnt_q + 32'd1;
  end

  assign o_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_intc_benes_pipe.sv
// Self-checking bench for intc_benes_pipe at PORTS=4, DATA_WIDTH=8: permutation table,
// streaming, stall, commit-with-beats-in-flight, mid-run reset and (optionally) the beat counter.
module tb_intc_benes_pipe;
  localparam int DW = 8;
  localparam int NP = 4;

  logic          clk, rst_n, i_valid, i_ready, o_valid, o_ready;
  logic          cfg_wr, cfg_commit, cfg_busy;
  logic [DW-1:0] i_data [0:NP-1];
  logic [DW-1:0] o_data [0:NP-1];
  logic [1:0]    cfg_stage, cfg_bits;
`ifdef INTC_BENES_BEAT_CNT_EN
  logic [31:0]   o_beat_cnt;
`endif
  int checks, errors;

  // Vectors pack port 0 in the top byte, so 32'hA0A1A2A3 reads as {A0,A1,A2,A3}.
  typedef struct packed {
    logic [1:0]  c0, c1, c2;
    logic [31:0] din, dout;
  } vec_t;
  vec_t vecs [0:5];

  intc_benes_pipe #(.DATA_WIDTH(DW), .PORTS(NP)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .cfg_wr(cfg_wr), .cfg_stage(cfg_stage), .cfg_bits(cfg_bits),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
`ifdef INTC_BENES_BEAT_CNT_EN
    , .o_beat_cnt(o_beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] packOut();
    return {o_data[0], o_data[1], o_data[2], o_data[3]};
  endfunction

  function automatic logic [31:0] beatVal(input int i);
    return {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)};
  endfunction

  task automatic driveData(input logic [31:0] v);
    for (int p = 0; p < NP; p++) i_data[p] = v[31-8*p -: 8];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic loadCfg(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                         input logic commit);
    int   n;
    logic seen;
    @(negedge clk); cfg_wr = 1'b1; cfg_stage = 2'd0; cfg_bits = c0;
    @(negedge clk); cfg_stage = 2'd1; cfg_bits = c1;
    @(negedge clk); cfg_stage = 2'd2; cfg_bits = c2; cfg_commit = commit;
    @(negedge clk); cfg_wr = 1'b0; cfg_commit = 1'b0;
    if (commit) begin
      #1;
      seen = cfg_busy;
      n = 0;
      while (cfg_busy && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("cfgBusySeen", 32'(seen), 32'd1);
      checkOutput("cfgBusyDone", 32'(cfg_busy), 32'd0);
    end
  endtask

  task automatic sendBeat(input logic [31:0] din, output int lat, output logic [31:0] got);
    @(negedge clk); o_ready = 1'b1; i_valid = 1'b1; driveData(din);
    @(negedge clk); i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    got = packOut();
  endtask

  task automatic applyStimulus(input vec_t v, output int lat, output logic [31:0] got);
    loadCfg(v.c0, v.c1, v.c2, 1'b1);
    sendBeat(v.din, lat, got);
  endtask

  // Streams n identity-permuted beats, optionally holding o_ready low for stallLen cycles.
  task automatic runStream(input int n, input int stallAt, input int stallLen, input string tag);
    int          sent, recv, firstK, lastK, stallBad, idle;
    logic [31:0] held;
    sent = 0; recv = 0; firstK = -1; lastK = -1; stallBad = 0; idle = 0; held = '0;
    for (int k = 0; k < 100 && recv < n; k++) begin
      @(negedge clk);
      o_ready = !(k >= stallAt && k < stallAt + stallLen);
      i_valid = (sent < n);
      driveData(beatVal(sent));
      #1;
      if (o_valid && o_ready) begin
        checkOutput({tag, "Data"}, packOut(), beatVal(recv));
        if (firstK < 0) firstK = k;
        lastK = k;
        recv++;
      end
      if (!o_ready) begin
        if (k == stallAt) held = packOut();
        if (i_ready || !o_valid || packOut() !== held) stallBad++;
      end
      if (i_valid && i_ready) sent++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); i_valid = 1'b0; o_ready = 1'b1;
      #1;
      if (o_valid) idle++;
    end
    checkOutput({tag, "Count"}, recv, n);
    checkOutput({tag, "First"}, firstK, 3);
    checkOutput({tag, "Span"}, lastK - firstK, n - 1 + stallLen);
    checkOutput({tag, "Extra"}, idle, 0);
    if (stallLen > 0) checkOutput({tag, "Hold"}, stallBad, 0);
  endtask

  // Three identity beats in flight when the commit arrives; the next beat must see all-cross.
  task automatic commitInFlight();
    int   sent, recv, busyRdy, acceptK;
    logic sawBusy;
    loadCfg(2'b11, 2'b11, 2'b11, 1'b0);
    sent = 0; recv = 0; busyRdy = 0; acceptK = -1; sawBusy = 1'b0;
    for (int k = 0; k < 40 && recv < 4; k++) begin
      @(negedge clk);
      o_ready    = 1'b1;
      cfg_commit = (k == 3);
      i_valid    = (k < 3) || (k >= 4 && sent == 3);
      driveData(sent < 3 ? beatVal(20 + sent) : 32'hC1C2C3C4);
      #1;
      if (cfg_busy) sawBusy = 1'b1;
      if (cfg_busy && i_ready) busyRdy++;
      if (o_valid) begin
        if (recv < 3) checkOutput("cmtOldPerm", packOut(), beatVal(20 + recv));
        else          checkOutput("cmtNewPerm", packOut(), 32'hC3C4C1C2);
        recv++;
      end
      if (i_valid && i_ready) begin
        if (sent == 3) acceptK = k;
        sent++;
      end
    end
    @(negedge clk); i_valid = 1'b0; cfg_commit = 1'b0;
    checkOutput("cmtBusySeen", 32'(sawBusy), 32'd1);
    checkOutput("cmtRdyBusy", busyRdy, 0);
    checkOutput("cmtAcceptAt", acceptK, 8);
    checkOutput("cmtOutCount", recv, 4);
  endtask

  initial begin
    int          lat;
    logic [31:0] got;
    checks = 0; errors = 0;
    rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    cfg_wr = 1'b0; cfg_commit = 1'b0; cfg_stage = 2'd0; cfg_bits = 2'd0;
    driveData(32'hFFFFFFFF);

    vecs[0] = '{2'b00, 2'b00, 2'b00, 32'h11223344, 32'h11223344};
    vecs[1] = '{2'b11, 2'b11, 2'b11, 32'hA0A1A2A3, 32'hA2A3A0A1};
    vecs[2] = '{2'b01, 2'b00, 2'b00, 32'h01020304, 32'h02010304};
    vecs[3] = '{2'b00, 2'b01, 2'b00, 32'h5A6B7C8D, 32'h7C6B5A8D};
    vecs[4] = '{2'b00, 2'b00, 2'b10, 32'hDEADBEEF, 32'hDEADEFBE};
    vecs[5] = '{2'b10, 2'b10, 2'b01, 32'h10203040, 32'h30104020};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstOValid", 32'(o_valid), 32'd0);
    checkOutput("rstIReady", 32'(i_ready), 32'd0);
    checkOutput("rstBusy", 32'(cfg_busy), 32'd0);
    checkOutput("rstOData", packOut(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checkOutput("relIReady", 32'(i_ready), 32'd1);

    sendBeat(32'hA0A1A2A3, lat, got);
    checkOutput("identLat", lat, 3);
    checkOutput("identData", got, 32'hA0A1A2A3);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], lat, got);
      checkOutput($sformatf("vecLat%0d", i), lat, 3);
      checkOutput($sformatf("vecPerm%0d", i), got, vecs[i].dout);
    end

    loadCfg(2'b00, 2'b00, 2'b00, 1'b1);
    runStream(10, 1000, 0, "strm");
    runStream(8, 5, 5, "stall");

    commitInFlight();

    @(negedge clk); o_ready = 1'b1; i_valid = 1'b1; driveData(32'h0A0B0C0D);
    cfg_wr = 1'b1; cfg_stage = 2'd0; cfg_bits = 2'b11;
    @(negedge clk); driveData(32'h1A1B1C1D); cfg_stage = 2'd2; cfg_commit = 1'b1;
    @(negedge clk); i_valid = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0; rst_n = 1'b0;
    #1;
    checkOutput("midRstOValid", 32'(o_valid), 32'd0);
    checkOutput("midRstOData", packOut(), 32'd0);
    checkOutput("midRstBusy", 32'(cfg_busy), 32'd0);
    checkOutput("midRstIReady", 32'(i_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checkOutput("postRstBusy", 32'(cfg_busy), 32'd0);
    sendBeat(32'h55667788, lat, got);
    checkOutput("postRstLat", lat, 3);
    checkOutput("postRstIdent", got, 32'h55667788);

`ifdef INTC_BENES_BEAT_CNT_EN
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1;
    checkOutput("cntAfterRst", o_beat_cnt, 32'd0);
    runStream(7, 1000, 0, "cnt");
    @(negedge clk); o_ready = 1'b0; i_valid = 1'b1; driveData(32'h99AABBCC);
    @(negedge clk); i_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("cntHeldValid", 32'(o_valid), 32'd1);
    checkOutput("cntSeven", o_beat_cnt, 32'd7);
    rst_n = 1'b0;
    #1;
    checkOutput("cntRstZero", o_beat_cnt, 32'd0);
    checkOutput("cntRstOValid", 32'(o_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1; o_ready = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
